// File: rtl/i2s_tdm_tx.sv
// I2S / left-justified TDM master transmitter.
// Generates SCLK and LRCK from clk_in and serialises one whole frame of
// CHANNELS samples per LRCK period, MSB first, each sample padded with
// zeros to SLOT_WIDTH bits. A one-deep holding buffer decouples the
// upstream handshake from the frame cadence.
//
// state | meaning
// IDLE  | no frame sent yet since reset; pins held low, bit counter at 0
// RUN   | streaming frames back to back; zeros plus underrun pulse when starved
`timescale 1ns/1ps
module i2s_tdm_tx #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32,
    parameter int CHANNELS     = 2,
    parameter int CLK_DIV      = 4
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             mode_in,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0] pdata_in,
    input  logic                             pvalid_in,
    output logic                             pready_out,
    output logic                             sclk_out,
    output logic                             lrck_out,
    output logic                             sdata_out,
    output logic                             underrun_out
);

    localparam int FRAME_BITS = CHANNELS * SLOT_WIDTH;
    localparam int PAR_W      = CHANNELS * SAMPLE_WIDTH;
    localparam int DIV_W      = $clog2(CLK_DIV);
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(FRAME_BITS / 2);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [DIV_W-1:0]      div_cnt;
    logic                  rise_evt;
    logic                  fall_evt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [BIT_W-1:0]      bit_nxt;
    logic [0:0]            state;
    logic [PAR_W-1:0]      holding;
    logic                  holding_full;
    logic [PAR_W-1:0]      frame_src;
    logic [FRAME_BITS-1:0] padded;
    logic [FRAME_BITS-1:0] shreg;
    logic                  delay_bit;
    logic                  mode_q;
    logic                  mode_eff;
    logic                  frame_start;
    logic                  cur_bit;

    assign rise_evt   = (div_cnt == DIV_RISE);
    assign fall_evt   = (div_cnt == DIV_LAST);
    assign pready_out = ~holding_full;

    // Frame-start detection, next bit index and the bit about to be emitted
    always_comb begin
        frame_start = fall_evt && (((state == IDLE) && holding_full) ||
                                   ((state == RUN) && (bit_cnt == BIT_LAST)));
        bit_nxt     = ((state == IDLE) || (bit_cnt == BIT_LAST)) ? '0 : bit_cnt + 1'b1;
        mode_eff    = frame_start ? mode_in : mode_q;
        cur_bit     = frame_start ? padded[FRAME_BITS-1] : shreg[FRAME_BITS-1];
    end

    // Lay the parallel frame out slot by slot, MSB first, zero padded
    always_comb begin
        frame_src = holding_full ? holding : '0;
        padded    = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            padded[FRAME_BITS-1-k*SLOT_WIDTH -: SAMPLE_WIDTH] =
                frame_src[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
    end

    // Free-running bit-clock divider; SCLK keeps toggling in every state
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            div_cnt  <= '0;
            sclk_out <= 1'b0;
        end else begin
            div_cnt <= fall_evt ? '0 : div_cnt + 1'b1;
            if (rise_evt) begin
                sclk_out <= 1'b1;
            end else if (fall_evt) begin
                sclk_out <= 1'b0;
            end
        end
    end

    // Holding buffer: a frame start drains it before any same-edge write
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            holding      <= '0;
            holding_full <= 1'b0;
        end else if (frame_start && holding_full) begin
            holding_full <= 1'b0;
        end else if (pvalid_in && pready_out) begin
            holding      <= pdata_in;
            holding_full <= 1'b1;
        end
    end

    // Serialiser and state: everything advances on SCLK falling events only
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            delay_bit <= 1'b0;
            mode_q    <= 1'b0;
            lrck_out  <= 1'b0;
            sdata_out <= 1'b0;
        end else if ((state == RUN) || frame_start) begin
            if (frame_start) begin
                state  <= RUN;
                mode_q <= mode_in;
                shreg  <= padded << 1;
            end else if (fall_evt) begin
                shreg <= shreg << 1;
            end
            if (fall_evt) begin
                bit_cnt   <= bit_nxt;
                lrck_out  <= (bit_nxt >= BIT_HALF);
                delay_bit <= cur_bit;
                sdata_out <= mode_eff ? cur_bit : delay_bit;
            end
        end
    end

    // Underrun pulse: a running stream reached a frame start with nothing queued
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            underrun_out <= 1'b0;
        end else begin
            underrun_out <= frame_start && (state == RUN) && !holding_full;
        end
    end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Directed bench for i2s_tdm_tx: a stereo instance for the I2S/LJ, underrun,
// back-to-back and reset scenarios, plus an 8-slot TDM instance.
`timescale 1ns/1ps
module tb_i2s_tdm_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        mode = 1'b1;
    logic [47:0] pdata = '0;
    logic        pvalid = 1'b0;
    logic        pready;
    logic        sclk;
    logic        lrck;
    logic        sdata;
    logic        ur;

    logic         t_mode = 1'b1;
    logic [127:0] t_pdata = '0;
    logic         t_pvalid = 1'b0;
    logic         t_pready;
    logic         t_sclk;
    logic         t_lrck;
    logic         t_sdata;
    logic         t_ur;

    int pass_cnt = 0;
    int total_cnt = 0;
    int ur_total = 0;
    int t_ur_total = 0;

    always #5 clk = ~clk;

    i2s_tdm_tx #(
        .SAMPLE_WIDTH(24), .SLOT_WIDTH(32), .CHANNELS(2), .CLK_DIV(4)
    ) dut (
        .clk_in(clk), .rst_in(rst), .mode_in(mode), .pdata_in(pdata),
        .pvalid_in(pvalid), .pready_out(pready), .sclk_out(sclk),
        .lrck_out(lrck), .sdata_out(sdata), .underrun_out(ur)
    );

    i2s_tdm_tx #(
        .SAMPLE_WIDTH(16), .SLOT_WIDTH(16), .CHANNELS(8), .CLK_DIV(4)
    ) dut_tdm (
        .clk_in(clk), .rst_in(rst), .mode_in(t_mode), .pdata_in(t_pdata),
        .pvalid_in(t_pvalid), .pready_out(t_pready), .sclk_out(t_sclk),
        .lrck_out(t_lrck), .sdata_out(t_sdata), .underrun_out(t_ur)
    );

    // Count clk cycles with the underrun flags high
    always @(negedge clk) begin
        if (ur === 1'b1) ur_total <= ur_total + 1;
        if (t_ur === 1'b1) t_ur_total <= t_ur_total + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        rst = 1'b1;
        pvalid = 1'b0;
        t_pvalid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [47:0] d);
        @(negedge clk);
        pdata = d;
        pvalid = 1'b1;
        while (pready !== 1'b1) @(negedge clk);
        @(posedge clk);
        #1;
        pvalid = 1'b0;
    endtask

    // Call just before a frame start; returns bit 0 in d[63]
    task automatic capture_frame(output logic [63:0] d, output logic [63:0] l);
        d = '0;
        l = '0;
        @(negedge sclk);
        for (int i = 0; i < 64; i++) begin
            @(posedge sclk);
            #1;
            d = {d[62:0], sdata};
            l = {l[62:0], lrck};
        end
    endtask

    task automatic test_reset();
        int highs;
        int noisy;
        rst = 1'b1;
        #12;
        total_cnt++; if (sclk !== 1'b0) $display("FAIL reset_sclk: got %b expected 0", sclk); else pass_cnt++;
        total_cnt++; if (lrck !== 1'b0) $display("FAIL reset_lrck: got %b expected 0", lrck); else pass_cnt++;
        total_cnt++; if (sdata !== 1'b0) $display("FAIL reset_sdata: got %b expected 0", sdata); else pass_cnt++;
        total_cnt++; if (ur !== 1'b0) $display("FAIL reset_underrun: got %b expected 0", ur); else pass_cnt++;
        total_cnt++; if (pready !== 1'b1) $display("FAIL reset_pready: got %b expected 1", pready); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        highs = 0;
        noisy = 0;
        repeat (40) begin
            @(negedge clk);
            if (sclk === 1'b1) highs++;
            if (lrck !== 1'b0 || sdata !== 1'b0) noisy++;
        end
        total_cnt++; if (highs !== 20) $display("FAIL idle_sclk_duty: got %0d high cycles expected 20", highs); else pass_cnt++;
        total_cnt++; if (noisy !== 0) $display("FAIL idle_pins_quiet: got %0d noisy cycles expected 0", noisy); else pass_cnt++;
    endtask

    task automatic test_lj();
        logic [63:0] d;
        logic [63:0] l;
        time t0;
        time t1;
        do_reset();
        mode = 1'b1;
        send_frame({24'h5A5A5A, 24'hA5A5A5});
        capture_frame(d, l);
        total_cnt++; if (d !== 64'hA5A5A500_5A5A5A00) $display("FAIL lj_data: got %h expected %h", d, 64'hA5A5A500_5A5A5A00); else pass_cnt++;
        total_cnt++; if (l !== 64'h00000000_FFFFFFFF) $display("FAIL lj_lrck: got %h expected %h", l, 64'h00000000_FFFFFFFF); else pass_cnt++;
        @(posedge sclk);
        t0 = $time;
        @(posedge sclk);
        t1 = $time;
        total_cnt++; if ((t1 - t0) !== 40) $display("FAIL sclk_period: got %0t expected 40", t1 - t0); else pass_cnt++;
    endtask

    task automatic test_i2s();
        logic [63:0] d;
        logic [63:0] l;
        do_reset();
        mode = 1'b0;
        send_frame({24'h5A5A5A, 24'hA5A5A5});
        capture_frame(d, l);
        total_cnt++; if (d !== 64'h52D2D280_2D2D2D00) $display("FAIL i2s_data: got %h expected %h", d, 64'h52D2D280_2D2D2D00); else pass_cnt++;
        total_cnt++; if (l !== 64'h00000000_FFFFFFFF) $display("FAIL i2s_lrck: got %h expected %h", l, 64'h00000000_FFFFFFFF); else pass_cnt++;
        mode = 1'b1;
    endtask

    task automatic test_underrun();
        logic [63:0] d;
        logic [63:0] l;
        int u0;
        do_reset();
        mode = 1'b1;
        send_frame({24'h654321, 24'h123456});
        capture_frame(d, l);
        total_cnt++; if (d !== 64'h12345600_65432100) $display("FAIL ur_first_data: got %h expected %h", d, 64'h12345600_65432100); else pass_cnt++;
        u0 = ur_total;
        fork
            capture_frame(d, l);
            begin
                repeat (100) @(negedge clk);
                send_frame({24'h800001, 24'hC00003});
            end
        join
        total_cnt++; if (d !== 64'h0) $display("FAIL ur_zero_data: got %h expected 0", d); else pass_cnt++;
        total_cnt++; if (l !== 64'h00000000_FFFFFFFF) $display("FAIL ur_lrck: got %h expected %h", l, 64'h00000000_FFFFFFFF); else pass_cnt++;
        total_cnt++; if ((ur_total - u0) !== 1) $display("FAIL ur_pulse_cycles: got %0d expected 1", ur_total - u0); else pass_cnt++;
        u0 = ur_total;
        capture_frame(d, l);
        total_cnt++; if (d !== 64'hC0000300_80000100) $display("FAIL ur_resume_data: got %h expected %h", d, 64'hC0000300_80000100); else pass_cnt++;
        total_cnt++; if ((ur_total - u0) !== 0) $display("FAIL ur_resume_pulse: got %0d expected 0", ur_total - u0); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [47:0] fr [4];
        logic [63:0] ev [4];
        logic [63:0] d;
        logic [63:0] l;
        int acc;
        int u0;
        fr[0] = {24'h222222, 24'h111111}; ev[0] = {24'h111111, 8'h00, 24'h222222, 8'h00};
        fr[1] = {24'h444444, 24'h333333}; ev[1] = {24'h333333, 8'h00, 24'h444444, 8'h00};
        fr[2] = {24'h666666, 24'h555555}; ev[2] = {24'h555555, 8'h00, 24'h666666, 8'h00};
        fr[3] = {24'h888888, 24'h777777}; ev[3] = {24'h777777, 8'h00, 24'h888888, 8'h00};
        do_reset();
        mode = 1'b1;
        acc = 0;
        u0 = ur_total;
        fork
            begin
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    pdata = fr[j];
                    pvalid = 1'b1;
                    while (pready !== 1'b1) @(negedge clk);
                    @(posedge clk);
                    #1;
                    total_cnt++; if (pready !== 1'b0) $display("FAIL b2b_ready_after_accept%0d: got %b expected 0", j, pready); else pass_cnt++;
                    acc++;
                end
                pvalid = 1'b0;
            end
            begin
                wait (acc >= 1);
                for (int f = 0; f < 4; f++) begin
                    fork
                        capture_frame(d, l);
                        begin
                            logic er;
                            er = (f < 3) ? 1'b0 : 1'b1;
                            @(negedge sclk);
                            #1;
                            total_cnt++; if (pready !== 1'b1) $display("FAIL b2b_ready_at_start%0d: got %b expected 1", f, pready); else pass_cnt++;
                            @(posedge clk);
                            #1;
                            total_cnt++; if (pready !== er) $display("FAIL b2b_ready_next_clk%0d: got %b expected %b", f, pready, er); else pass_cnt++;
                        end
                    join
                    total_cnt++; if (d !== ev[f]) $display("FAIL b2b_frame%0d: got %h expected %h", f, d, ev[f]); else pass_cnt++;
                end
            end
        join
        total_cnt++; if ((ur_total - u0) !== 0) $display("FAIL b2b_no_underrun: got %0d expected 0", ur_total - u0); else pass_cnt++;
    endtask

    task automatic test_tdm();
        logic [127:0] d;
        logic [127:0] l;
        logic [15:0]  ev;
        logic [15:0]  el;
        int u0;
        do_reset();
        t_mode = 1'b1;
        for (int k = 0; k < 8; k++) t_pdata[k*16 +: 16] = 16'(16'h1000 + k);
        @(negedge clk);
        t_pvalid = 1'b1;
        while (t_pready !== 1'b1) @(negedge clk);
        @(posedge clk);
        #1;
        t_pvalid = 1'b0;
        u0 = t_ur_total;
        d = '0;
        l = '0;
        @(negedge t_sclk);
        for (int i = 0; i < 128; i++) begin
            @(posedge t_sclk);
            #1;
            d = {d[126:0], t_sdata};
            l = {l[126:0], t_lrck};
        end
        for (int k = 0; k < 8; k++) begin
            ev = 16'(16'h1000 + k);
            el = (k >= 4) ? 16'hFFFF : 16'h0000;
            total_cnt++; if (d[127-16*k -: 16] !== ev) $display("FAIL tdm_slot%0d: got %h expected %h", k, d[127-16*k -: 16], ev); else pass_cnt++;
            total_cnt++; if (l[127-16*k -: 16] !== el) $display("FAIL tdm_lrck%0d: got %h expected %h", k, l[127-16*k -: 16], el); else pass_cnt++;
        end
        total_cnt++; if ((t_ur_total - u0) !== 0) $display("FAIL tdm_no_underrun: got %0d expected 0", t_ur_total - u0); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic [63:0] d;
        logic [63:0] l;
        int noisy;
        do_reset();
        mode = 1'b1;
        send_frame({24'h5A5A5A, 24'hA5A5A5});
        @(negedge sclk);
        repeat (42) @(posedge sclk);
        #2;
        total_cnt++; if (sdata !== 1'b1) $display("FAIL pre_reset_sdata: got %b expected 1", sdata); else pass_cnt++;
        total_cnt++; if (lrck !== 1'b1) $display("FAIL pre_reset_lrck: got %b expected 1", lrck); else pass_cnt++;
        total_cnt++; if (sclk !== 1'b1) $display("FAIL pre_reset_sclk: got %b expected 1", sclk); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++; if (sclk !== 1'b0) $display("FAIL async_sclk: got %b expected 0", sclk); else pass_cnt++;
        total_cnt++; if (lrck !== 1'b0) $display("FAIL async_lrck: got %b expected 0", lrck); else pass_cnt++;
        total_cnt++; if (sdata !== 1'b0) $display("FAIL async_sdata: got %b expected 0", sdata); else pass_cnt++;
        total_cnt++; if (ur !== 1'b0) $display("FAIL async_underrun: got %b expected 0", ur); else pass_cnt++;
        total_cnt++; if (pready !== 1'b1) $display("FAIL async_pready: got %b expected 1", pready); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        noisy = 0;
        repeat (300) begin
            @(negedge clk);
            if (lrck !== 1'b0 || sdata !== 1'b0) noisy++;
        end
        total_cnt++; if (noisy !== 0) $display("FAIL post_reset_quiet: got %0d noisy cycles expected 0", noisy); else pass_cnt++;
        send_frame({24'h0F0F0F, 24'hF0F0F0});
        capture_frame(d, l);
        total_cnt++; if (d !== 64'hF0F0F000_0F0F0F00) $display("FAIL post_reset_data: got %h expected %h", d, 64'hF0F0F000_0F0F0F00); else pass_cnt++;
        total_cnt++; if (l !== 64'h00000000_FFFFFFFF) $display("FAIL post_reset_lrck: got %h expected %h", l, 64'h00000000_FFFFFFFF); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_lj();
        test_i2s();
        test_underrun();
        test_back_to_back();
        test_tdm();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
